// File: rtl/truth_table_checker_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_checker_pkg
// Shared definitions for the truth-table checker: FSM state encoding and the
// helper that sizes the settle counter from the SETTLE parameter.
// No ports (package).
// -----------------------------------------------------------------------------
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Counter only has to reach SETTLE-1; keep at least one bit.
    function automatic int settle_cnt_w(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// -----------------------------------------------------------------------------
// truth_table_checker_settle_timer
// Counts the cycles a vector has been held in APPLY. Cleared on entry to
// APPLY, counts while enabled, and flags expired once SETTLE cycles have
// been spent (count == SETTLE-1).
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   clr     - synchronous clear of the count (priority over en)
//   en      - count enable
//   expired - count has reached SETTLE-1
// -----------------------------------------------------------------------------
module truth_table_checker_settle_timer #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            // Hold at terminal count so the counter never wraps.
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == TERM);

endmodule

// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
// Sweeps all 2**N_IN input vectors of a gate-under-test, holds each for
// SETTLE cycles, samples the gate output and compares it with TRUTH.
// Counts mismatches and captures the first failing vector.
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   APPLY  | driving vec, waiting SETTLE cycles
//   SAMPLE | comparing dut_out against TRUTH[vec]
//   DONE   | sweep finished, results frozen until next start
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   start       - begin a sweep (honoured in IDLE/DONE only)
//   dut_in      - vector driven to the gate-under-test
//   dut_out     - gate-under-test output
//   busy        - sweep in progress (APPLY/SAMPLE)
//   done        - sweep complete (level)
//   pass        - valid with done; no mismatches seen
//   err_count   - mismatches in current/last sweep
//   fail_valid  - a mismatch has been captured
//   fail_vec    - first mismatching vector
// -----------------------------------------------------------------------------
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter logic [2**N_IN-1:0]    TRUTH  = 4'b1000,
    parameter int                    SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   fail_vec
);

    // One extra bit so the last-vector compare never aliases with vector 0.
    localparam int              VEC_W = N_IN + 1;
    localparam logic [VEC_W-1:0] LAST = VEC_W'(2**N_IN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [VEC_W-1:0] vec;
    logic             timer_clr;
    logic             timer_en;
    logic             expired;
    logic             sweep_load;
    logic             mismatch;

    truth_table_checker_settle_timer #(
        .SETTLE (SETTLE),
        .CNT_W  (settle_cnt_w(SETTLE))
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    assign mismatch = (dut_out != TRUTH[vec[N_IN-1:0]]);

    always_comb begin
        state_nxt  = state;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        sweep_load = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt  = ST_APPLY;
                    timer_clr  = 1'b1;
                    sweep_load = 1'b1;
                end
            end
            ST_APPLY: begin
                timer_en = 1'b1;
                if (expired) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (vec == LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_APPLY;
                    timer_clr = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            state <= state_nxt;
            if (sweep_load) begin
                vec        <= '0;
                err_count  <= '0;
                fail_valid <= 1'b0;
                fail_vec   <= '0;
            end else if (state == ST_SAMPLE) begin
                if (mismatch) begin
                    err_count <= err_count + 1'b1;
                    if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec[N_IN-1:0];
                    end
                end
                // vec stays on the last vector in DONE so dut_in is frozen.
                if (vec != LAST) begin
                    vec <= vec + 1'b1;
                end
            end
        end
    end

    assign dut_in = vec[N_IN-1:0];
    assign busy   = (state == ST_APPLY) || (state == ST_SAMPLE);
    assign done   = (state == ST_DONE);
    assign pass   = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    localparam logic [3:0] TRUTH_A = 4'b1000;
    localparam logic [7:0] TRUTH_B = 8'h80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b;
    logic [3:0] gate_a;
    logic [7:0] gate_b;

    logic [1:0] dut_in_a, fail_vec_a;
    logic       dut_out_a, busy_a, done_a, pass_a, fail_valid_a;
    logic [2:0] err_a;

    logic [2:0] dut_in_b, fail_vec_b;
    logic       dut_out_b, busy_b, done_b, pass_b, fail_valid_b;
    logic [3:0] err_b;

    // Ideal gate models: output is the gate table looked up by the applied vector.
    assign dut_out_a = gate_a[dut_in_a];
    assign dut_out_b = gate_b[dut_in_b];

    truth_table_checker #(.N_IN(2), .TRUTH(TRUTH_A), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_valid(fail_valid_a), .fail_vec(fail_vec_a)
    );

    truth_table_checker #(.N_IN(3), .TRUTH(TRUTH_B), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_valid(fail_valid_b), .fail_vec(fail_vec_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hist_b[8];
    int bad_step;
    int both_high;

    typedef struct {
        string      name;
        logic [3:0] gate;
        int         glitch;
        int         err;
        int         fvalid;
        int         fvec;
        int         pass;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Pulse start, then count edges until done (start-assert edge counts as 1).
    task automatic sweep(input int which, input int glitch_at, output int cyc);
        int         budget;
        logic       dn;
        logic [2:0] prev;
        budget    = (which == 0) ? 40 : 100;
        bad_step  = 0;
        both_high = 0;
        prev      = '0;
        for (int v = 0; v < 8; v++) hist_b[v] = 0;
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        cyc = 0;
        dn  = 1'b0;
        while (!dn && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (cyc == glitch_at) begin
                if (which == 0) start_a = 1'b1; else start_b = 1'b1;
            end
            if (which == 0) begin
                dn = done_a;
                if (busy_a && done_a) both_high++;
            end else begin
                dn = done_b;
                if (busy_b && done_b) both_high++;
                if (busy_b) begin
                    hist_b[dut_in_b]++;
                    if (dut_in_b != prev && dut_in_b != prev + 3'd1) bad_step++;
                    prev = dut_in_b;
                end
            end
        end
        if (!dn) check("sweep_timeout", 0, 1);
    endtask

    // Reference: mismatch count is the popcount of the differing table bits;
    // first failure is the lowest differing vector.
    function automatic int first_diff(input logic [7:0] diff);
        for (int i = 0; i < 8; i++) if (diff[i]) return i;
        return 0;
    endfunction

    task automatic check_a(input string nm, input logic [3:0] gate, input int cyc);
        logic [7:0] diff;
        int e;
        diff = {4'b0, gate ^ TRUTH_A};
        e    = $countones(diff);
        check({nm, "_cycles"}, cyc, 9);
        check({nm, "_err"}, int'(err_a), e);
        check({nm, "_fvalid"}, int'(fail_valid_a), (e != 0) ? 1 : 0);
        check({nm, "_fvec"}, int'(fail_vec_a), first_diff(diff));
        check({nm, "_pass"}, int'(pass_a), (e == 0) ? 1 : 0);
        check({nm, "_busy_done"}, both_high, 0);
    endtask

    task automatic check_b(input string nm, input logic [7:0] gate, input int cyc);
        logic [7:0] diff;
        int e;
        diff = gate ^ TRUTH_B;
        e    = $countones(diff);
        check({nm, "_cycles"}, cyc, 33);
        check({nm, "_err"}, int'(err_b), e);
        check({nm, "_fvalid"}, int'(fail_valid_b), (e != 0) ? 1 : 0);
        check({nm, "_fvec"}, int'(fail_vec_b), first_diff(diff));
        check({nm, "_pass"}, int'(pass_b), (e == 0) ? 1 : 0);
        check({nm, "_busy_done"}, both_high, 0);
    endtask

    task automatic check_idle_a(input string nm);
        check({nm, "_dut_in"}, int'(dut_in_a), 0);
        check({nm, "_busy"}, int'(busy_a), 0);
        check({nm, "_done"}, int'(done_a), 0);
        check({nm, "_pass"}, int'(pass_a), 0);
        check({nm, "_err"}, int'(err_a), 0);
        check({nm, "_fvalid"}, int'(fail_valid_a), 0);
        check({nm, "_fvec"}, int'(fail_vec_a), 0);
    endtask

    vec_t tab[7];
    int   cyc;

    initial begin
        tab[0] = '{"and2_ideal",   4'b1000, -1, 0, 0, 0, 1};
        tab[1] = '{"stuck0",       4'b0000, -1, 1, 1, 3, 0};
        tab[2] = '{"and2_restart", 4'b1000, -1, 0, 0, 0, 1};
        tab[3] = '{"or2_glitch",   4'b1110,  3, 2, 1, 1, 0};
        tab[4] = '{"xor2",         4'b0110, -1, 3, 1, 1, 0};
        tab[5] = '{"nand2",        4'b0111, -1, 4, 1, 0, 0};
        tab[6] = '{"stuck1",       4'b1111,  6, 3, 1, 0, 0};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        gate_a = 4'b1000; gate_b = 8'h80;
        repeat (3) @(posedge clk);
        #1;
        check_idle_a("reset_a");
        check("reset_b_busy", int'(busy_b), 0);
        check("reset_b_done", int'(done_b), 0);
        check("reset_b_err", int'(err_b), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven sweeps on the 2-input checker, back to back without reset.
        for (int i = 0; i < 7; i++) begin
            gate_a = tab[i].gate;
            sweep(0, tab[i].glitch, cyc);
            check({tab[i].name, "_cycles"}, cyc, 9);
            check({tab[i].name, "_err"}, int'(err_a), tab[i].err);
            check({tab[i].name, "_fvalid"}, int'(fail_valid_a), tab[i].fvalid);
            check({tab[i].name, "_fvec"}, int'(fail_vec_a), tab[i].fvec);
            check({tab[i].name, "_pass"}, int'(pass_a), tab[i].pass);
            check({tab[i].name, "_done"}, int'(done_a), 1);
            check({tab[i].name, "_busy_done"}, both_high, 0);
            repeat (2) @(posedge clk);
            #1;
            check({tab[i].name, "_frozen_err"}, int'(err_a), tab[i].err);
            check({tab[i].name, "_frozen_dut_in"}, int'(dut_in_a), 3);
        end

        // 3-input AND, SETTLE=3: 33 cycles, each vector held 4 cycles in order.
        gate_b = 8'h80;
        sweep(1, 10, cyc);
        check_b("and3", gate_b, cyc);
        for (int v = 0; v < 8; v++) check($sformatf("and3_hold_v%0d", v), hist_b[v], 4);
        check("and3_step_order", bad_step, 0);

        // Reset in the middle of vector 2.
        gate_a = 4'b0000;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_v2_dut_in", int'(dut_in_a), 2);
        check("mid_v2_busy", int'(busy_a), 1);
        rst = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start_a = 1'b0;
        check_idle_a("mid_rst");
        @(posedge clk); #1;
        check("mid_rst_stays_idle", int'(busy_a), 0);

        // Randomized gate tables against the reference model.
        for (int r = 0; r < 12; r++) begin
            gate_a = ($urandom_range(0, 3) == 0) ? TRUTH_A : 4'($urandom_range(0, 15));
            sweep(0, (r % 2 == 0) ? $urandom_range(1, 7) : -1, cyc);
            check_a($sformatf("rnd_a%0d", r), gate_a, cyc);
        end
        for (int r = 0; r < 12; r++) begin
            gate_b = ($urandom_range(0, 3) == 0) ? TRUTH_B : 8'($urandom);
            sweep(1, (r % 2 == 0) ? $urandom_range(1, 31) : -1, cyc);
            check_b($sformatf("rnd_b%0d", r), gate_b, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
